mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and owns the HI/LO registers.
- Sequences multi-cycle operations with a busy counter.
- Raises a stall request to hold any MDU-class instruction in D while an operation is starting or in flight.

---
 rtl/mdu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the E stage.
// Owns the architectural HI/LO registers and sequences mult/multu/div/divu
// over a fixed busy window, committing the precomputed result at its end.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   req_D       - instruction in D is MDU-class
//   op_E        - E-stage MDU op (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none)
//   A_E, B_E    - forwarded rs/rt operands in E
//   busy        - registered, operation in flight
//   stall       - combinational stall request to the hazard unit
//   HI, LO      - registered architectural HI/LO
//   mf_out      - combinational mfhi/mflo result for E
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_D,
  input  logic [3:0]  op_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_p_q, hi_p_d;
  logic [31:0]        lo_p_q, lo_p_d;
  logic               wr_p_q, wr_p_d;

  logic               is_mult;
  logic               is_div;
  logic               start;

  // Operation decode; a start is only accepted while idle.
  assign is_mult = (op_E == OP_MULT) || (op_E == OP_MULTU);
  assign is_div  = (op_E == OP_DIV)  || (op_E == OP_DIVU);
  assign start   = (is_mult || is_div) && !busy_q;

  // Multiplier: operands extended to 64 bits, sign-extended only for mult.
  logic        mul_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  assign mul_sgn = (op_E == OP_MULT);
  assign mul_a   = {{32{mul_sgn & A_E[31]}}, A_E};
  assign mul_b   = {{32{mul_sgn & B_E[31]}}, B_E};
  assign prod    = mul_a * mul_b;

  // Divider on magnitudes; signs restored afterwards so the quotient truncates
  // toward zero and the remainder follows the dividend. This also keeps the
  // most-negative / -1 case free of signed-overflow corner cases.
  logic        div_sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  assign div_sgn  = (op_E == OP_DIV);
  assign a_neg    = div_sgn & A_E[31];
  assign b_neg    = div_sgn & B_E[31];
  assign a_mag    = a_neg ? 32'(~A_E + 32'd1) : A_E;
  assign b_mag    = b_neg ? 32'(~B_E + 32'd1) : B_E;
  assign div_zero = (B_E == 32'd0);
  assign q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quot     = (a_neg ^ b_neg) ? 32'(~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? 32'(~r_mag + 32'd1) : r_mag;

  // Next-state: start capture, busy countdown, commit, and mthi/mtlo writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    wr_p_d  = wr_p_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          if (is_mult) begin
            cnt_d  = CNT_W'(MULT_CYCLES);
            hi_p_d = prod[63:32];
            lo_p_d = prod[31:0];
            wr_p_d = 1'b1;
          end else begin
            cnt_d  = CNT_W'(DIV_CYCLES);
            hi_p_d = rem;
            lo_p_d = quot;
            // A divide by zero still occupies the unit but leaves HI/LO alone.
            wr_p_d = !div_zero;
          end
        end else if (op_E == OP_MTHI) begin
          hi_d = A_E;
        end else if (op_E == OP_MTLO) begin
          lo_d = A_E;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (wr_p_q) begin
            hi_d = hi_p_q;
            lo_d = lo_p_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
      wr_p_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      wr_p_q  <= wr_p_d;
    end
  end

  // Move-from read path.
  always_comb begin
    mf_out = 32'd0;
    if (op_E == OP_MFHI) begin
      mf_out = hi_q;
    end else if (op_E == OP_MFLO) begin
      mf_out = lo_q;
    end
  end

  // Hold an MDU instruction in D while an operation is starting or running.
  assign stall = req_D & (busy_q | start);

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random stimulus for mdu_ctrl, checked each cycle
// against a transaction-level model (absolute cycle of the last busy cycle,
// pending result computed with 64-bit integer arithmetic).
module tb_mdu_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        req_D;
  logic [3:0]  op_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mf_out;

  int checks   = 0;
  int failures = 0;

  // Model state
  int          cyc        = 0;
  int          busy_until = -1;
  bit          m_valid    = 1'b0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_D  (req_D),
    .op_E   (op_E),
    .A_E    (A_E),
    .B_E    (B_E),
    .busy   (busy),
    .stall  (stall),
    .HI     (HI),
    .LO     (LO),
    .mf_out (mf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference arithmetic from the architectural definition.
  function automatic void md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit wr);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = m_hi;
    lo = m_lo;
    wr = 1'b1;
    case (op)
      4'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      4'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      4'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_until;
  endfunction

  task automatic check_outputs();
    bit          st;
    logic [31:0] mf;
    if (!m_valid) return;
    st = (op_E >= 4'd1 && op_E <= 4'd4) && !m_busy();
    mf = (op_E == 4'd5) ? m_hi : (op_E == 4'd6) ? m_lo : 32'd0;
    chk("busy",   {31'd0, busy},  {31'd0, m_busy()});
    chk("HI",     HI,             m_hi);
    chk("LO",     LO,             m_lo);
    chk("stall",  {31'd0, stall}, {31'd0, req_D & (m_busy() | st)});
    chk("mf_out", mf_out,         mf);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit b_now;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; p_wr = 1'b0;
      busy_until = cyc;
      m_valid = 1'b1;
    end else if (m_valid) begin
      b_now = m_busy();
      if (b_now) begin
        if (cyc == busy_until && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (op_E >= 4'd1 && op_E <= 4'd4) begin
        md_ref(op_E, A_E, B_E, p_hi, p_lo, p_wr);
        busy_until = cyc + ((op_E <= 4'd2) ? int'(MULT_N) : int'(DIV_N));
      end else if (op_E == 4'd7) begin
        m_hi = A_E;
      end else if (op_E == 4'd8) begin
        m_lo = A_E;
      end
    end
    cyc++;
  endtask

  task automatic step(input logic rq, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rst);
    reset = rst; req_D = rq; op_E = op; A_E = a; B_E = b;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic rq);
    for (int i = 0; i < n; i++) step(rq, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_D = 1'b0; op_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // mult -3*5 with a following MDU instruction in D; second mult while busy.
    step(1, 4'd1, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_pre_lo", LO, 32'd0);
    step(1, 4'd1, 32'd7, 32'd9, 0);
    idle(4, 1'b1);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);
    step(1, 4'd6, 0, 0, 0);

    // divu 17/5 and div -7/2.
    step(0, 4'd4, 32'd17, 32'd5, 0);
    idle(DIV_N, 1'b0);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd2);
    step(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    idle(DIV_N, 1'b0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // mthi idle, mfhi; mtlo while busy is dropped.
    step(0, 4'd7, 32'h1234_5678, 0, 0);
    chk("mthi", HI, 32'h1234_5678);
    step(1, 4'd5, 0, 0, 0);
    step(0, 4'd2, 32'd2, 32'd3, 0);
    step(0, 4'd8, 32'hDEAD_BEEF, 0, 0);
    idle(4, 1'b0);
    chk("mtlo_busy", LO, 32'd6);

    // Reset during busy cycle 3 of a div: no later commit.
    step(0, 4'd3, 32'd100, 32'd7, 0);
    idle(2, 1'b0);
    step(0, 4'd0, 0, 0, 1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    idle(DIV_N + 2, 1'b0);
    chk("rst_lo", LO, 32'd0);

    // Divide by zero keeps HI/LO.
    step(0, 4'd7, 32'hAAAA_0001, 0, 0);
    step(0, 4'd8, 32'h5555_0002, 0, 0);
    step(1, 4'd3, 32'd9, 32'd0, 0);
    idle(DIV_N, 1'b1);
    chk("dz_hi", HI, 32'hAAAA_0001);
    chk("dz_lo", LO, 32'h5555_0002);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int unsigned r;
      r  = $urandom_range(0, 23);
      op = (r < 16) ? 4'(r) : 4'd0;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'(-$signed(b));
      step(1'($urandom_range(0, 1)), op, a, b, 1'($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
